gf_digit_serial_mul: RTL
========================

# gf_digit_serial_mul

Digit-serial GF(2^W) multiplier, the parametrised successor to the serial CLM multiplier. It computes out = p1·p2 mod P(x) over GF(2) with a runtime-supplied reduction polynomial. It consumes D bits of p2 per cycle, so one product takes W/D cycles. It sits behind the same drdy_i/drdy_o handshake the CLM datapath already uses, and adds a busy indication plus optional consumer back-pressure.

## Interface
- W, 8, field degree; operand and result width.
- D, 1, digit size in bits per cycle; 1 ≤ D ≤ W, W % D == 0 (elaboration-time assertion).
- N (localparam), W/D, digits per product.
- clk  in  1  clock; single clock domain, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- drdy_i  in  1  operands valid; sampled only when not busy.
- p1  in  W  multiplicand a(x), bit i = coefficient of x^i.
- p2  in  W  multiplier b(x), consumed MSB digit first.
- P  in  W  low W coefficients of monic reduction polynomial; x^W implied.
- busy  out  1  operation in progress; drdy_i ignored while high.
- drdy_o  out  1  result valid.
- out  out  W  product register.
- ready_i  in  1  consumer accepts result (only with GFMUL_BACKPRESSURE_EN).

## Operation
- States: IDLE, RUN, DONE (DONE exists only with GFMUL_BACKPRESSURE_EN).
- IDLE and drdy_i=1: latch p1, P, p2 into a_r, p_r, b_r. Set acc=0, digit counter cnt=N-1, busy=1, go to RUN. p1/p2/P may change freely afterwards.
- RUN, each cycle: for j = D-1 down to 0, acc = xtime(acc) ^ (b_r[W-1-(D-1-j)] ? a_r : 0). Here xtime(v) = (v<<1)[W-1:0] ^ (v[W-1] ? p_r : 0). Then shift b_r left by D.
- RUN with cnt==0: out <= final acc and drdy_o <= 1.
  - Without the macro: busy <= 0, state <= IDLE.
  - With the macro: state <= DONE, busy stays 1.
- Otherwise in RUN, cnt decrements.
- DONE: drdy_o and busy stay high and out is stable. When ready_i=1 is sampled: drdy_o <= 0, busy <= 0, state <= IDLE.
- All arithmetic is carry-less (XOR). Result is fully reduced, W bits. A non-irreducible P still yields the deterministic polynomial result mod P.
- drdy_i high while busy: ignored, no queuing, no error flag.
- Reset (any state, including mid-RUN/DONE): state=IDLE, busy=0, drdy_o=0, out=0, acc=0, cnt=0. An aborted operation produces no drdy_o.

## Timing
- drdy_i sampled high at edge k (IDLE) → busy high after edge k. Digits are processed at edges k+1 … k+N.
- drdy_o and out valid after edge k+N. Latency is N cycles from the accept edge.
- Without the macro:
  - drdy_o is a one-cycle pulse; busy low in the same cycle drdy_o is high.
  - A drdy_i in that cycle is accepted at edge k+N+1. Peak throughput is one product per N+1 cycles.
  - out holds its value until the next completion.
- With the macro: a ready_i already high in the drdy_o cycle completes the handshake at the next edge. Throughput is one product per N+2 cycles at best.
- D=W: N=1, full product in one RUN cycle.

## Configuration
- GFMUL_BACKPRESSURE_EN defined: ready_i port present, DONE state present, drdy_o held until ready_i.
- Undefined: no ready_i port, no DONE state, drdy_o is a single-cycle pulse and the consumer must capture it.

## Test plan
- W=8, D=1, P=8'h1B: p1=8'h57, p2=8'h83, drdy_i one cycle → drdy_o exactly 8 cycles after the accept edge, out=8'hC1, one-cycle pulse.
- W=8, D=4 and D=8, same P: 8'h57·8'h13 → out=8'hFE, latency 2 and 1 respectively. Also 8'h01·8'hA5 → 8'hA5, and 8'h00·8'hFF → 8'h00.
- Busy handling and back-to-back:
  - drdy_i held high with new operands while busy → ignored, first result unchanged.
  - Drive 8'h02·8'h80 (→8'h1B) in the drdy_o cycle → accepted next edge, second result correct.
- Reset mid-operation:
  - rst high at cycle 3 of RUN → next cycle busy=0, drdy_o=0, out=0; no drdy_o ever appears for the aborted op.
  - A fresh op afterwards gives the correct result.
- GFMUL_BACKPRESSURE_EN, ready_i held low 5 cycles after completion → drdy_o, busy and out=8'hC1 stable for all 5 cycles, drdy_i ignored. ready_i=1 → next cycle drdy_o=0, busy=0.
- Randomised check against a bit-level reference model: 1000 random (p1, p2) with P=8'h1B for W=8, and P=16'h002B for W=16, D ∈ {1,2,4}. Operands are changed immediately after accept to prove latching.

Source files
------------

// File: rtl/gf_digit_serial_mul.sv
// Digit-serial GF(2^W) multiplier: out = p1*p2 mod (x^W + P), D bits of p2 per cycle, N = W/D cycles.
// Define GFMUL_BACKPRESSURE_EN to hold drdy_o in a DONE state until ready_i is sampled high.
module gf_digit_serial_mul #(
   parameter int W = 8,
   parameter int D = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         drdy_i,
   input  logic [W-1:0] p1,
   input  logic [W-1:0] p2,
   input  logic [W-1:0] P,
   output logic         busy,
   output logic         drdy_o,
   output logic [W-1:0] out
`ifdef GFMUL_BACKPRESSURE_EN
   ,
   input  logic         ready_i
`endif
);

   localparam int N  = W / D;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if (D < 1 || D > W || (W % D) != 0) begin : g_bad_digit
      $error("gf_digit_serial_mul: D must divide W and satisfy 1 <= D <= W");
   end

`ifdef GFMUL_BACKPRESSURE_EN
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`else
   typedef enum logic [0:0] {IDLE, RUN} state_t;
`endif

   state_t         state, state_nxt;
   logic [W-1:0]   a_r, p_r, b_r, acc, acc_step;
   logic [CW-1:0]  cnt;
   logic           last_digit;

   assign last_digit = (cnt == '0);

   // Horner step over one digit: MSB of the digit enters first.
   always_comb begin
      acc_step = acc;
      for (int j = D - 1; j >= 0; j--) begin
         acc_step = {acc_step[W-2:0], 1'b0}
                  ^ (acc_step[W-1] ? p_r : '0)
                  ^ (b_r[W-D+j]    ? a_r : '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (drdy_i) state_nxt = RUN;
         RUN: begin
            if (last_digit) begin
`ifdef GFMUL_BACKPRESSURE_EN
               state_nxt = DONE;
`else
               state_nxt = IDLE;
`endif
            end
         end
`ifdef GFMUL_BACKPRESSURE_EN
         DONE: if (ready_i) state_nxt = IDLE;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_r    <= '0;
         p_r    <= '0;
         b_r    <= '0;
         acc    <= '0;
         cnt    <= '0;
         out    <= '0;
         drdy_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               drdy_o <= 1'b0;
               if (drdy_i) begin
                  a_r <= p1;
                  p_r <= P;
                  b_r <= p2;
                  acc <= '0;
                  cnt <= CW'(N - 1);
               end
            end
            RUN: begin
               acc <= acc_step;
               b_r <= b_r << D;
               if (last_digit) begin
                  out    <= acc_step;
                  drdy_o <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
`ifdef GFMUL_BACKPRESSURE_EN
            DONE: if (ready_i) drdy_o <= 1'b0;
`endif
            default: drdy_o <= 1'b0;
         endcase
      end
   end

endmodule
